// File: rtl/bank_call_display.sv
// Hall call board: detects new "ticket N to desk D" calls from the ticket machine,
// queues them, and presents each one with a chime pulse followed by a hold time.
module bank_call_display #(
  parameter int DEPTH        = 4,
  parameter int CHIME_CYCLES = 4,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               Tickernum,
  input  logic [1:0]               Desknum,
  input  logic [2:0]               ticket_ServiceType,
  output logic [6:0]               disp_ticket,
  output logic [1:0]               disp_desk,
  output logic [2:0]               disp_service,
  output logic                     disp_valid,
  output logic                     chime,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int MAXT = (CHIME_CYCLES > HOLD_CYCLES) ? CHIME_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int EW   = 12;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] CHIME_LD = TW'(CHIME_CYCLES);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [1:0] {IDLE, CHIME, SHOW} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [8:0]      prev;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [EW-1:0]   head;
  logic            new_call, full, empty, pop, push, drop;

  // A call is a change of {ticket, desk} to a non-zero ticket; service changes alone are ignored.
  assign new_call = (Tickernum != 7'd0) && ({Tickernum, Desknum} != prev);
  assign full     = (queue_count == FULL_CNT);
  assign empty    = (queue_count == '0);
  assign push     = new_call && (!full || pop);
  assign drop     = new_call && full && !pop;
  assign head     = mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          timer_nxt = CHIME_LD;
          state_nxt = CHIME;
        end
      end
      CHIME: begin
        if (timer == TIMER_ONE) begin
          timer_nxt = HOLD_LD;
          state_nxt = SHOW;
        end else begin
          timer_nxt = timer - TIMER_ONE;
        end
      end
      SHOW: begin
        if (timer == TIMER_ONE) begin
          if (!empty) begin
            pop       = 1'b1;
            timer_nxt = CHIME_LD;
            state_nxt = CHIME;
          end else begin
            timer_nxt = '0;
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer - TIMER_ONE;
        end
      end
      default: begin
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      chime <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      chime <= (state_nxt == CHIME);
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {Tickernum, Desknum, ticket_ServiceType};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      overflow    <= 1'b0;
    end else begin
      prev <= {Tickernum, Desknum};
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   queue_count <= queue_count + CW'(1);
        2'b01:   queue_count <= queue_count - CW'(1);
        default: queue_count <= queue_count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_ticket  <= '0;
      disp_desk    <= '0;
      disp_service <= '0;
      disp_valid   <= 1'b0;
    end else if (pop) begin
      disp_ticket  <= head[11:5];
      disp_desk    <= head[4:3];
      disp_service <= head[2:0];
      disp_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bank_call_display.sv
// Directed, table-driven bench for the hall call board with default parameters.
module tb_bank_call_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Tickernum = '0;
  logic [1:0] Desknum = '0;
  logic [2:0] ticket_ServiceType = '0;
  logic [6:0] disp_ticket;
  logic [1:0] disp_desk;
  logic [2:0] disp_service;
  logic       disp_valid;
  logic       chime;
  logic [2:0] queue_count;
  logic       overflow;

  bank_call_display #(.DEPTH(4), .CHIME_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .Tickernum(Tickernum), .Desknum(Desknum), .ticket_ServiceType(ticket_ServiceType),
    .disp_ticket(disp_ticket), .disp_desk(disp_desk), .disp_service(disp_service),
    .disp_valid(disp_valid), .chime(chime), .queue_count(queue_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [6:0] t;
    logic [1:0] d;
    logic [2:0] s;
    int         reps;
    logic [6:0] et;
    logic [1:0] ed;
    logic [2:0] es;
    logic       ev;
    logic       ec;
    logic [2:0] eq;
    logic       eo;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  function automatic void add(input logic r, input logic [6:0] t, input logic [1:0] d,
                              input logic [2:0] s, input int reps,
                              input logic [6:0] et, input logic [1:0] ed, input logic [2:0] es,
                              input logic ev, input logic ec, input logic [2:0] eq,
                              input logic eo);
    vec_t v;
    v.rst = r; v.t = t; v.d = d; v.s = s; v.reps = reps;
    v.et = et; v.ed = ed; v.es = es; v.ev = ev; v.ec = ec; v.eq = eq; v.eo = eo;
    tbl.push_back(v);
  endfunction

  function automatic logic [17:0] outs();
    return {disp_ticket, disp_desk, disp_service, disp_valid, chime, queue_count, overflow};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got t=%0d d=%0d s=%b v=%b c=%b q=%0d o=%b, expected t=%0d d=%0d s=%b v=%b c=%b q=%0d o=%b",
                  name, got[17:11], got[10:9], got[8:6], got[5], got[4], got[3:1], got[0],
                  exp[17:11], exp[10:9], exp[8:6], exp[5], exp[4], exp[3:1], exp[0]);
  endtask

  initial begin
    // reset, then idle with no calls
    add(1, 0,0,0, 2,  0,0,0, 0,0,0,0);
    add(0, 0,0,0, 10, 0,0,0, 0,0,0,0);
    // single call: queued at E, shown at E+1, 4 chime + 16 hold, then idle keeps display
    add(0, 5,0,1, 1,  0,0,0, 0,0,1,0);
    add(0, 5,0,1, 4,  5,0,1, 1,1,0,0);
    add(0, 5,0,1, 16, 5,0,1, 1,0,0,0);
    add(0, 5,0,1, 3,  5,0,1, 1,0,0,0);
    // back-to-back calls on consecutive cycles
    add(1, 0,0,0, 2,  0,0,0, 0,0,0,0);
    add(0, 5,0,1, 1,  0,0,0, 0,0,1,0);
    add(0, 6,1,2, 1,  5,0,1, 1,1,1,0);
    add(0, 7,2,4, 3,  5,0,1, 1,1,2,0);
    add(0, 7,2,4, 16, 5,0,1, 1,0,2,0);
    add(0, 7,2,4, 4,  6,1,2, 1,1,1,0);
    add(0, 7,2,4, 16, 6,1,2, 1,0,1,0);
    add(0, 7,2,4, 4,  7,2,4, 1,1,0,0);
    add(0, 7,2,4, 18, 7,2,4, 1,0,0,0);
    // service-only changes and ticket 0 are not calls
    add(1, 0,0,0, 2,  0,0,0, 0,0,0,0);
    add(0, 9,1,1, 1,  0,0,0, 0,0,1,0);
    add(0, 9,1,1, 4,  9,1,1, 1,1,0,0);
    add(0, 9,1,1, 25, 9,1,1, 1,0,0,0);
    add(0, 9,1,2, 3,  9,1,1, 1,0,0,0);
    add(0, 9,1,4, 3,  9,1,1, 1,0,0,0);
    add(0, 0,1,4, 3,  9,1,1, 1,0,0,0);
    add(0, 0,0,0, 3,  9,1,1, 1,0,0,0);
    // same ticket, new desk
    add(1, 0,0,0, 2,  0,0,0, 0,0,0,0);
    add(0, 9,1,1, 1,  0,0,0, 0,0,1,0);
    add(0, 9,3,1, 4,  9,1,1, 1,1,1,0);
    add(0, 9,3,1, 16, 9,1,1, 1,0,1,0);
    add(0, 9,3,1, 4,  9,3,1, 1,1,0,0);
    add(0, 9,3,1, 17, 9,3,1, 1,0,0,0);
    // overflow: fill queue during chime, fifth push dropped, flag sticky
    add(1, 0,0,0, 2,  0,0,0, 0,0,0,0);
    add(0, 1,0,1, 1,  0,0,0, 0,0,1,0);
    add(0, 2,0,1, 1,  1,0,1, 1,1,1,0);
    add(0, 3,0,1, 1,  1,0,1, 1,1,2,0);
    add(0, 4,0,1, 1,  1,0,1, 1,1,3,0);
    add(0, 5,0,1, 1,  1,0,1, 1,1,4,0);
    add(0, 6,0,1, 1,  1,0,1, 1,0,4,1);
    add(0, 6,0,1, 15, 1,0,1, 1,0,4,1);
    add(0, 6,0,1, 2,  2,0,1, 1,1,3,1);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        Tickernum          = tbl[i].t;
        Desknum            = tbl[i].d;
        ticket_ServiceType = tbl[i].s;
        rst_n              = !tbl[i].rst;
        @(posedge clk);
        #1;
        check($sformatf("row%0d.%0d", i, k), outs(),
              {tbl[i].et, tbl[i].ed, tbl[i].es, tbl[i].ev, tbl[i].ec, tbl[i].eq, tbl[i].eo});
      end
    end

    // asynchronous reset in the middle of a chime clears outputs without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), 18'd0);
    @(posedge clk);
    #1;
    check("rst_held", outs(), 18'd0);
    rst_n = 1'b1;
    Tickernum = '0;
    @(posedge clk);
    #1;
    check("after_rst", outs(), 18'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bank_call_display.md
# bank_call_display

Customer-facing call board for the bank ticket system. It watches the call outputs of the ticket machine (`Tickernum`, `Desknum`, `ticket_ServiceType`) and detects each new "ticket N to desk D" call. Detected calls are queued in a small FIFO and presented one at a time on the hall display, with a chime pulse followed by a minimum hold time. It sits between the ticket machine FSM and the display/speaker drivers.

## Interface
- `DEPTH`, 4: call queue entries (power of 2, ≥2).
- `CHIME_CYCLES`, 4: cycles `chime` is high per presented call (≥1).
- `HOLD_CYCLES`, 16: cycles a call stays displayed after chime before the next may replace it (≥1).

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `Tickernum`  in  7  ticket number currently called by the ticket machine; 0 = no call.
- `Desknum`  in  2  desk (officer 1–4 encoded 0–3) for the current call.
- `ticket_ServiceType`  in  3  one-hot service of the current call (001 general, 010 loan, 100 customer service).
- `disp_ticket`  out  7  ticket shown on the board.
- `disp_desk`  out  2  desk shown.
- `disp_service`  out  3  service shown.
- `disp_valid`  out  1  board shows a call.
- `chime`  out  1  high during chime phase of a freshly presented call.
- `queue_count`  out  log2(DEPTH)+1  entries waiting in the queue.
- `overflow`  out  1  sticky; set when a call is dropped because the queue was full.

## Operation
- Call detection: register `prev = {Tickernum, Desknum}`, reset 0. A new call is present in a cycle when `Tickernum != 0` and `{Tickernum, Desknum} != prev`. `prev` updates every cycle.
  - A change of `ticket_ServiceType` alone is not a new call.
  - The same ticket on a different desk is a new call.
  - A transition to `Tickernum == 0` is ignored.
- Push: a new call writes `{Tickernum, Desknum, ticket_ServiceType}` into the FIFO at that clock edge.
  - If the queue is full and there is no pop in the same cycle, the call is dropped and `overflow` is set.
  - If the queue is full and a pop occurs in the same cycle, the push is accepted and nothing is dropped.
- FSM states: IDLE, CHIME, SHOW.
  - IDLE: if `queue_count > 0`, pop the head into the `disp_*` registers, set `disp_valid = 1`, load the timer with `CHIME_CYCLES`, go to CHIME.
  - CHIME: `chime = 1`. The timer decrements each cycle. At expiry, load `HOLD_CYCLES` and go to SHOW.
  - SHOW: `chime = 0`. The timer decrements. At expiry:
    - if the queue is non-empty, pop the next call directly into `disp_*`, reload `CHIME_CYCLES`, go to CHIME;
    - otherwise go to IDLE.
- In IDLE the last call remains displayed (`disp_valid` stays 1 once any call has been shown).
- `queue_count` reflects push/pop in the same cycle: a push and a pop together leave it unchanged.
- The FIFO uses wrapping read/write pointers of `log2(DEPTH)` bits plus a separate count. The count never exceeds `DEPTH` and never underflows.

## Timing
- Reset (asynchronous, any time including mid-chime):
  - `disp_ticket = 0`, `disp_desk = 0`, `disp_service = 0`, `disp_valid = 0`, `chime = 0`, `queue_count = 0`, `overflow = 0`.
  - FSM goes to IDLE, `prev = 0`, pointers cleared. Queued calls are discarded.
- Latency, idle board with empty queue: input change sampled at edge E → queued at E → `disp_*`, `disp_valid` and `chime` update at E+1.
- `chime` is high for exactly `CHIME_CYCLES` consecutive cycles per presented call.
- A presented call occupies the board for exactly `CHIME_CYCLES + HOLD_CYCLES` cycles before the next queued call replaces it, with no gap cycle between them.
- Calls arriving on consecutive cycles are each captured (one push per cycle).
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- Reset then idle: hold `rst_n = 0` for 2 cycles, then inputs at 0 for 10 cycles → all outputs 0, `disp_valid = 0`, `chime` never asserted.
- Single call: `Tickernum = 5`, `Desknum = 0`, `ticket_ServiceType = 001` → one cycle later `disp_ticket = 5`, `disp_desk = 0`, `disp_service = 001`, `chime` high for 4 cycles. After 20 cycles total the FSM is in IDLE and the display is still 5/0.
- Back-to-back calls: inputs change to (5,d0), (6,d1), (7,d2) on consecutive cycles → `queue_count` peaks at 2. Board shows 5, then 6 exactly 20 cycles later, then 7 after a further 20 cycles. Three chime pulses of 4 cycles each.
- Non-calls filtered: hold (9,d1) for 30 cycles, toggle only `ticket_ServiceType`, then set `Tickernum = 0` → exactly one call presented, `queue_count` stays 0.
- Same ticket, new desk: (9,d1) then (9,d3) → two presentations, second with `disp_desk = 3`.
- Overflow: with the board in CHIME, push 5 distinct calls in 5 cycles (`DEPTH = 4`) → `queue_count = 4`, the 5th call is dropped, `overflow = 1` and it stays 1. Assert `rst_n` low mid-chime → all outputs return to 0 immediately.
